// File: rtl/rf_hop_sched.sv
// Frequency-hop scheduler: table of frequency words issued per pre-CPI edge.
// Optional pseudo-random hop order when RF_HOP_LFSR_EN is defined.
module rf_hop_sched #(
    parameter int FREQ_W     = 16,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4,
    parameter int SETTLE_CYC = 200
`ifdef RF_HOP_LFSR_EN
    ,
    parameter logic [7:0] LFSR_SEED = 8'hA5
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tbl_wr,
    input  logic [IDX_W-1:0]  i_tbl_addr,
    input  logic [FREQ_W-1:0] i_tbl_data,
    input  logic [IDX_W:0]    i_tbl_len,
    input  logic              i_init,
    input  logic              i_stop,
    input  logic              i_pre_cpi,
    input  logic              i_tx_over_flag,
    output logic [FREQ_W-1:0] o_rf_freq,
    output logic              o_rf_freq_vld,
    output logic              o_settle_done,
    output logic [IDX_W-1:0]  o_hop_idx,
    output logic              o_busy,
    output logic              o_err_overrun
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ISSUE,
        S_SETTLE,
        S_WAIT_TX
    } state_t;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  tbl_q [DEPTH];
    logic [IDX_W:0]     len_q, len_in;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               pre_d, pre_edge;
    logic               init_acc, issue_go, tx_acc, ovr_set;

    assign pre_edge = i_pre_cpi & ~pre_d;
    assign o_busy   = state_q inside {S_ISSUE, S_SETTLE, S_WAIT_TX};
    assign init_acc = i_init & ~i_stop &
                      (state_q == S_IDLE || state_q == S_ARMED);
    assign issue_go = (state_q == S_ARMED) & pre_edge & ~i_init & ~i_stop;
    assign tx_acc   = (state_q == S_WAIT_TX) & i_tx_over_flag & ~i_stop;
    assign ovr_set  = o_busy & pre_edge & ~i_stop;

    assign o_rf_freq_vld = (state_q == S_ISSUE);
    assign o_settle_done = (state_q == S_SETTLE) && (cnt_q == '0);

    always_comb begin
        len_in = i_tbl_len;
        if (i_tbl_len == '0)
            len_in = (IDX_W+1)'(1);
        else if (i_tbl_len > LEN_MAX)
            len_in = LEN_MAX;
    end

`ifdef RF_HOP_LFSR_EN
    localparam int MW = (IDX_W + 1 > 8) ? IDX_W + 1 : 8;
    logic [7:0]    lfsr_q, lfsr_adv;
    logic [MW-1:0] lfsr_mod;

    // taps for x^8+x^6+x^5+x^4+1
    assign lfsr_adv = {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign lfsr_mod = MW'(lfsr_adv) % MW'(len_q);
    assign idx_nxt  = lfsr_mod[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_q <= LFSR_SEED;
        else if (init_acc)
            lfsr_q <= LFSR_SEED;
        else if (tx_acc)
            lfsr_q <= lfsr_adv;
    end
`else
    assign idx_nxt = ({1'b0, idx_q} == len_q - 1'b1) ? '0 : idx_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (i_init) state_d = S_ARMED;
            S_ARMED:   if (!i_init && pre_edge) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_SETTLE;
            S_SETTLE:  if (cnt_q == '0) state_d = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_over_flag) state_d = S_ARMED;
            default:   state_d = S_IDLE;
        endcase
        if (i_stop)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_q[i] <= '0;
        end else if (i_tbl_wr) begin
            tbl_q[i_tbl_addr] <= i_tbl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pre_d         <= 1'b0;
            len_q         <= (IDX_W+1)'(1);
            idx_q         <= '0;
            cnt_q         <= '0;
            o_rf_freq     <= '0;
            o_hop_idx     <= '0;
            o_err_overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_d   <= i_pre_cpi;
            if (init_acc) begin
                len_q <= len_in;
                idx_q <= '0;
            end else if (tx_acc) begin
                idx_q <= idx_nxt;
            end
            // table read here is the pre-write value on a same-cycle write
            if (issue_go) begin
                o_rf_freq <= tbl_q[idx_q];
                o_hop_idx <= idx_q;
            end
            if (i_stop)
                cnt_q <= '0;
            else if (state_q == S_ISSUE)
                cnt_q <= CNT_W'(SETTLE_CYC - 1);
            else if (state_q == S_SETTLE && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (init_acc)
                o_err_overrun <= 1'b0;
            else if (ovr_set)
                o_err_overrun <= 1'b1;
        end
    end

endmodule

// File: doc/rf_hop_sched.md
# rf_hop_sched

Frequency-hop scheduler that sequences the RF frequency-word datapath. It holds a programmable table of up to DEPTH 16-bit frequency words. On each pre-CPI rising edge it issues the next word as a one-cycle valid strobe, then times the synthesizer settle window. It then waits for transmit-over before advancing the hop index, and flags pre-CPI requests that arrive while a hop is still in progress.

## Interface
- FREQ_W, 16, frequency word width
- DEPTH, 16, table entries; power of two, ≥2
- IDX_W, 4, log2(DEPTH)
- SETTLE_CYC, 200, settle window length in clk cycles; ≥1
- LFSR_SEED, 8'hA5, non-zero LFSR seed (used only with RF_HOP_LFSR_EN)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_tbl_wr  in  1  table write strobe
- i_tbl_addr  in  IDX_W  table write address
- i_tbl_data  in  FREQ_W  table write data
- i_tbl_len  in  IDX_W+1  entries in use; latched on accepted i_init
- i_init  in  1  pulse: arm the hop sequence from index 0
- i_stop  in  1  pulse: abort to IDLE
- i_pre_cpi  in  1  synchronous level; a rising edge requests the next hop
- i_tx_over_flag  in  1  pulse: transmission on the current frequency complete
- o_rf_freq  out  FREQ_W  issued frequency word; reset 0
- o_rf_freq_vld  out  1  one-cycle strobe with a new o_rf_freq; reset 0
- o_settle_done  out  1  one-cycle pulse at the end of the settle window; reset 0
- o_hop_idx  out  IDX_W  index of the word most recently issued; reset 0
- o_busy  out  1  high in ISSUE/SETTLE/WAIT_TX; reset 0
- o_err_overrun  out  1  sticky; a pre-CPI edge was dropped; reset 0

## Operation
- Table: DEPTH×FREQ_W registers, reset 0. Writes are accepted in any state.
  - A write and an issue to the same entry in the same cycle: the issued word is the old data (read-before-write).
- Length latch: len = i_tbl_len, clamped; 0 → 1, >DEPTH → DEPTH.
- Edge detect: pre_d registers i_pre_cpi; edge = i_pre_cpi & ~pre_d. pre_d resets to 0.
- FSM states: IDLE, ARMED, ISSUE, SETTLE, WAIT_TX. Reset state is IDLE.
  - IDLE: i_init → latch len, idx=0, clear o_err_overrun → ARMED.
  - ARMED: edge → ISSUE. i_init re-latches len, idx=0, and clears overrun.
  - ISSUE (1 cycle): o_rf_freq=tbl[idx], o_rf_freq_vld=1, o_hop_idx=idx, load settle counter → SETTLE.
  - SETTLE: counts SETTLE_CYC cycles; on the last one pulse o_settle_done → WAIT_TX.
  - WAIT_TX: i_tx_over_flag → idx = next(idx) → ARMED.
- Sequential next(idx): (idx==len-1) ? 0 : idx+1.
- In ISSUE, SETTLE or WAIT_TX:
  - An edge sets o_err_overrun and is dropped.
  - i_init is ignored.
  - i_tx_over_flag is ignored outside WAIT_TX.
- i_stop in any state → IDLE next cycle. i_stop has priority over i_init, edge and i_tx_over_flag in the same cycle.
  - o_rf_freq and o_hop_idx hold their last values.
  - The settle counter clears; no o_settle_done is produced.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous); the table clears.

## Timing
- i_pre_cpi first sampled high at edge k (ARMED) → ISSUE at k+1, with o_rf_freq_vld high during cycle k+1.
- o_settle_done high during cycle k+1+SETTLE_CYC.
- i_tx_over_flag sampled at edge m in WAIT_TX → ARMED at m+1. A new pre-CPI edge sampled at m+1 is accepted.
- o_busy is registered with the state: high from cycle k+1 through cycle m.
- i_init in IDLE at edge j → ARMED at j+1.

## Configuration
- RF_HOP_LFSR_EN defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) loads LFSR_SEED on reset and on every accepted i_init.
  - It advances once per accepted i_tx_over_flag.
  - next(idx) = post-advance LFSR value mod len.
- RF_HOP_LFSR_EN undefined: sequential wrap order; no LFSR logic is synthesized.

## Test plan
- Write tbl[0..3]=0x1000,0x1001,0x1002,0x1003; len=4; i_init; 5 pre-CPI/tx-over cycles → o_rf_freq sequence 0x1000,0x1001,0x1002,0x1003,0x1000. Each vld is 1 cycle after the edge; settle_done is 200 cycles after vld.
- Pre-CPI edge during SETTLE → o_err_overrun=1, no extra vld. A following i_init clears it.
- i_stop on cycle 50 of SETTLE → IDLE next cycle, no o_settle_done, o_rf_freq holds 0x1001. i_init plus edge → index 0 reissued.
- i_tbl_len=0 → len=1, o_rf_freq repeats tbl[0]. i_tbl_len=20 → wraps after index 15.
- Write tbl[idx]=0xBEEF in the ISSUE cycle → old value issued; 0xBEEF issued on the next wrap.
- i_tx_over_flag during SETTLE is ignored (stays in SETTLE). i_stop and i_init in the same cycle → IDLE.
